// File: rtl/conf_regs_rx_pkg.sv
// Shared encodings and defaults for the UART-to-config-register frame parser.
// CONF_* widths mirror the configuration register file defaults.
package conf_regs_rx_pkg;

  localparam int CONF_ADDR_WIDTH    = 8;
  localparam int CONF_DATA_WIDTH    = 8;
  localparam int RX_WIDTH           = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1200000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CHK  = 2'd2,
    ST_PUSH = 2'd3
  } state_t;

  // Data bytes per frame.
  function automatic int byte_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/conf_regs_rx_if.sv
// UART byte stream in, register write out, plus the frame-discard pulse.
// master = the parser, slave = UART/register-file side.
interface conf_regs_rx_if #(
  parameter int ADDR_WIDTH = conf_regs_rx_pkg::CONF_ADDR_WIDTH,
  parameter int DATA_WIDTH = conf_regs_rx_pkg::CONF_DATA_WIDTH
);
  import conf_regs_rx_pkg::*;

  logic [RX_WIDTH-1:0]   rx_data;
  logic                  rx_rdy;
  logic                  rx_ack;
  logic [ADDR_WIDTH-1:0] register_addr;
  logic [DATA_WIDTH-1:0] register_data;
  logic                  register_rdy;
  logic                  register_ack;
  logic                  frame_error;

  modport master (
    input  rx_data, rx_rdy, register_ack,
    output rx_ack, register_addr, register_data, register_rdy, frame_error
  );

  modport slave (
    output rx_data, rx_rdy, register_ack,
    input  rx_ack, register_addr, register_data, register_rdy, frame_error
  );

endinterface

// File: rtl/conf_rx_timeout.sv
// Inter-byte gap watchdog: loadable down-counter, expire when it has run out.
// Latency: expire is combinational from the count; clr reloads on the next edge.
// Backpressure: none; en freezes nothing, it only gates counting and expire.
module conf_rx_timeout #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt_q <= LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/conf_regs_rx.sv
// Frame parser: addr byte + DATA_WIDTH/8 data bytes (LSB first) [+ XOR byte if CONF_RX_CHECKSUM_EN].
// Latency: register_rdy rises the cycle after the final byte is consumed.
// Backpressure: rx_ack held low while a write waits for register_ack (no timeout there).
module conf_regs_rx
  import conf_regs_rx_pkg::*;
#(
  parameter int ADDR_WIDTH     = CONF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = CONF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic            clk,
  input logic            rst,
  conf_regs_rx_if.master bus
);

  localparam int            NB       = byte_count(DATA_WIDTH);
  localparam int            IW       = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ferr_q;
  logic                  rx_ack_c, wr_rdy_c;
  logic                  xfer, tmo_en, expire;
`ifdef CONF_RX_CHECKSUM_EN
  logic [RX_WIDTH-1:0]   chk_q;
`endif

  assign xfer   = bus.rx_rdy && rx_ack_c;
  assign tmo_en = (state_q == ST_DATA) || (state_q == ST_CHK);

  conf_rx_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (xfer || !tmo_en),
    .en     (tmo_en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (xfer) state_d = ST_DATA;
      ST_DATA: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
`ifdef CONF_RX_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_PUSH;
`endif
          end
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
`ifdef CONF_RX_CHECKSUM_EN
      ST_CHK: begin
        if (xfer)        state_d = (bus.rx_data == chk_q) ? ST_PUSH : ST_IDLE;
        else if (expire) state_d = ST_IDLE;
      end
`endif
      ST_PUSH: if (bus.register_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Both handshakes are gated by rst so nothing transfers during reset.
  always_comb begin
    rx_ack_c = 1'b0;
    wr_rdy_c = 1'b0;
    if (rst) begin
      rx_ack_c = (state_q != ST_PUSH);
      wr_rdy_c = (state_q == ST_PUSH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      ferr_q <= 1'b0;
`ifdef CONF_RX_CHECKSUM_EN
      chk_q  <= '0;
`endif
    end else begin
      ferr_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (xfer) begin
          addr_q <= bus.rx_data[ADDR_WIDTH-1:0];
          idx_q  <= '0;
`ifdef CONF_RX_CHECKSUM_EN
          chk_q  <= bus.rx_data;
`endif
        end
        ST_DATA: begin
          if (xfer) begin
            data_q[{idx_q, 3'b000} +: 8] <= bus.rx_data;
            idx_q <= idx_q + 1'b1;
`ifdef CONF_RX_CHECKSUM_EN
            chk_q <= chk_q ^ bus.rx_data;
`endif
          end else if (expire) begin
            ferr_q <= 1'b1;
          end
        end
`ifdef CONF_RX_CHECKSUM_EN
        ST_CHK: begin
          if (xfer)        ferr_q <= (bus.rx_data != chk_q);
          else if (expire) ferr_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.rx_ack        = rx_ack_c;
  assign bus.register_rdy  = wr_rdy_c;
  assign bus.register_addr = addr_q;
  assign bus.register_data = data_q;
  assign bus.frame_error   = ferr_q;

endmodule

// File: tb/tb_conf_regs_rx.sv
// Scoreboard bench for conf_regs_rx: DATA_WIDTH=16, TIMEOUT_CYCLES=16; follows CONF_RX_CHECKSUM_EN.
module tb_conf_regs_rx;
  import conf_regs_rx_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ferr_cnt = 0;
  int ferr_cyc = 0;
  int n_writes = 0;
  int ack_mode = 0;   // 0: hold off, 1: random accept, 2: accept at once
  logic [23:0] exp_q[$];

  conf_regs_rx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  conf_regs_rx #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-file side: decide ack away from the edge; a write is taken on the next posedge.
  always @(negedge clk) begin
    logic        ack;
    logic [23:0] e;
    if (bus.frame_error === 1'b1) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    case (ack_mode)
      1:       ack = bus.register_rdy && ($urandom_range(0, 2) == 0);
      2:       ack = bus.register_rdy;
      default: ack = 1'b0;
    endcase
    if (ack && rst) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_write", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_val("sb_addr", 32'(bus.register_addr), 32'(e[23:16]));
        check_val("sb_data", 32'(bus.register_data), 32'(e[15:0]));
      end
      n_writes++;
    end
    bus.register_ack = ack;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    while (bus.rx_ack !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("rx_ack_wait", 32'(bus.rx_ack), 1);
    @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input int gap, input bit rnd);
    logic [7:0] bytes[4];
    int nb;
    bytes[0] = a;
    bytes[1] = d[7:0];
    bytes[2] = d[15:8];
    bytes[3] = a ^ d[7:0] ^ d[15:8];
`ifdef CONF_RX_CHECKSUM_EN
    nb = 4;
`else
    nb = 3;
`endif
    exp_q.push_back({a, d});
    for (int i = 0; i < nb; i++) begin
      if (i > 0) repeat (rnd ? int'($urandom_range(0, gap)) : gap) @(posedge clk);
      send_byte(bytes[i]);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_val("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f0, w0;
    bit seen;
    bus.rx_data = '0;
    bus.rx_rdy  = 1'b0;

    // Reset values
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rx_ack", 32'(bus.rx_ack), 0);
    check_val("rst_rdy",    32'(bus.register_rdy), 0);
    check_val("rst_addr",   32'(bus.register_addr), 0);
    check_val("rst_data",   32'(bus.register_data), 0);
    check_val("rst_ferr",   32'(bus.frame_error), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_val("idle_rx_ack", 32'(bus.rx_ack), 1);

    // Back-to-back frame, register file stalls 5 cycles
    ack_mode = 0;
    exp_q.push_back({8'h03, 16'h1234});
    send_byte(8'h03);
    send_byte(8'h34);
    check_val("rdy_early", 32'(bus.register_rdy), 0);
    send_byte(8'h12);
`ifdef CONF_RX_CHECKSUM_EN
    check_val("rdy_before_chk", 32'(bus.register_rdy), 0);
    send_byte(8'h03 ^ 8'h34 ^ 8'h12);
`endif
    check_val("rdy_rise",  32'(bus.register_rdy), 1);
    check_val("push_addr", 32'(bus.register_addr), 32'h03);
    check_val("push_data", 32'(bus.register_data), 32'h1234);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_val("stall_rx_ack", 32'(bus.rx_ack), 0);
      check_val("stall_rdy",    32'(bus.register_rdy), 1);
      check_val("stall_addr",   32'(bus.register_addr), 32'h03);
      check_val("stall_data",   32'(bus.register_data), 32'h1234);
    end
    ack_mode = 2;
    @(posedge clk);
    #1;
    check_val("rdy_fall", 32'(bus.register_rdy), 0);
    check_val("t1_written", exp_q.size(), 0);

    // Inter-byte timeout after the address byte
    f0 = ferr_cnt;
    w0 = n_writes;
    send_byte(8'h05);
    c0 = cyc;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 seen |= bus.register_rdy;
    end
    check_val("tmo_ferr_count", ferr_cnt - f0, 1);
    check_val("tmo_ferr_cycle", ferr_cyc - c0, TMO);
    check_val("tmo_no_rdy", 32'(seen), 0);
    check_val("tmo_no_write", n_writes - w0, 0);
    send_frame(8'h07, 16'h55AA, 0, 1'b0);
    wait_drain(50);

    // Each byte arrives in the last cycle before expiry
    f0 = ferr_cnt;
    send_frame(8'h11, 16'hBEEF, TMO - 1, 1'b0);
    wait_drain(50);
    check_val("edge_no_ferr", ferr_cnt - f0, 0);

`ifdef CONF_RX_CHECKSUM_EN
    // Wrong checksum byte
    f0 = ferr_cnt;
    w0 = n_writes;
    send_byte(8'h02);
    send_byte(8'h0F);
    send_byte(8'h00);
    send_byte(8'h02 ^ 8'h0F ^ 8'h01);
    repeat (3) @(posedge clk);
    #1;
    check_val("chk_bad_ferr", ferr_cnt - f0, 1);
    check_val("chk_bad_no_write", n_writes - w0, 0);
    send_frame(8'h02, 16'h000F, 0, 1'b0);
    wait_drain(50);
`endif

    // Reset while a write is pending
    ack_mode = 0;
    f0 = ferr_cnt;
    w0 = n_writes;
    send_byte(8'h21);
    send_byte(8'h21);
    send_byte(8'h43);
`ifdef CONF_RX_CHECKSUM_EN
    send_byte(8'h21 ^ 8'h21 ^ 8'h43);
`endif
    check_val("pre_rst_rdy", 32'(bus.register_rdy), 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_rdy",    32'(bus.register_rdy), 0);
    check_val("midrst_addr",   32'(bus.register_addr), 0);
    check_val("midrst_data",   32'(bus.register_data), 0);
    check_val("midrst_rx_ack", 32'(bus.rx_ack), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 ack_mode = 2;
    send_frame(8'h09, 16'h0A0B, 0, 1'b0);
    wait_drain(50);
    check_val("midrst_no_ferr", ferr_cnt - f0, 0);
    check_val("midrst_writes", n_writes - w0, 1);

    // Random frames with byte jitter and random write stalls
    ack_mode = 1;
    f0 = ferr_cnt;
    w0 = n_writes;
    for (int i = 0; i < 50; i++) begin
      send_frame(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 3, 1'b1);
    end
    wait_drain(500);
    check_val("rand_writes", n_writes - w0, 50);
    check_val("rand_no_ferr", ferr_cnt - f0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conf_regs_rx.md
Name: conf_regs_rx

Overview:
- Byte-stream parser between the UART receiver and the configuration register file.
- Assembles frames of one address byte, DATA_WIDTH/8 data bytes (LSB first) and, optionally, one checksum byte.
- Presents each complete frame as one address/data write on the register write simple interface (register_addr/register_data/register_rdy/register_ack).
- Drops partial frames after an inter-byte timeout, which resynchronises the stream.

Parameters:
- ADDR_WIDTH, 8: register address width. Must be ≤ 8; the low ADDR_WIDTH bits of the address byte are used.
- DATA_WIDTH, 8: register data width. Must be a multiple of 8, maximum 32.
- RX_WIDTH, 8: UART byte width. Fixed at 8.
- TIMEOUT_CYCLES, 1200000: maximum allowed gap, in clk cycles, between bytes of one frame.

Ports:
- clk  input  1  fpga clock
- rst  input  1  synchronous reset, active-low (0 = reset)
- rx_data  input  RX_WIDTH  received byte
- rx_rdy  input  1  rx_data valid
- rx_ack  output  1  byte accepted; combinational
- register_addr  output  ADDR_WIDTH  write address
- register_data  output  DATA_WIDTH  write data
- register_rdy  output  1  write valid
- register_ack  input  1  write accepted by register file
- frame_error  output  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - register_addr=0, register_data=0, register_rdy=0, frame_error=0.
  - Byte counter, timeout counter and checksum accumulator cleared.
  - rx_ack=0 while rst=0.
- Byte transfer: a byte is consumed on a clk edge where rx_rdy=1 and rx_ack=1.
  - rx_ack=1 in IDLE, ADDR_DONE, DATA and CHK.
  - rx_ack=0 in PUSH, which back-pressures the UART.
- States:
  - IDLE: a byte transfer latches the address (low ADDR_WIDTH bits), seeds checksum=byte, goes to DATA with byte index 0.
  - DATA: the transfer at byte index k writes register_data[8k+7:8k] and XORs the byte into the checksum.
    - After the last byte (k = DATA_WIDTH/8-1), goes to CHK if the checksum feature is compiled in, otherwise PUSH.
  - CHK: optional state; see Optional Feature.
  - PUSH: register_rdy=1. On the edge with register_rdy=1 and register_ack=1, register_rdy falls to 0 and state returns to IDLE.
- ADDR_DONE is not a separate state; address capture happens on the IDLE transfer.
- Latency:
  - register_rdy rises in the cycle after the edge that consumes the final byte (data byte, or checksum if enabled).
  - Minimum frame-to-frame period is (1 + DATA_WIDTH/8 [+1]) byte transfers plus 1 PUSH cycle.
- register_addr and register_data hold stable while register_rdy=1. They may update only in IDLE/DATA, never in PUSH.
- Timeout:
  - Counter is cleared on every byte transfer and held at 0 in IDLE and PUSH.
  - In DATA/CHK, when the counter reaches TIMEOUT_CYCLES-1 with no transfer: state→IDLE, frame_error pulses one cycle, partial data is discarded (registers keep their last values; register_rdy is not asserted).
  - A byte transfer in the same cycle as expiry wins: the byte is consumed and the counter is cleared.
- No timeout in PUSH: the register file may stall indefinitely.
- Reset mid-frame or mid-PUSH: the frame is discarded, register_rdy=0 on the following cycle, and no frame_error pulse.
- rx_rdy is ignored while rx_ack=0. No byte is lost: the UART holds rx_rdy until acknowledged.

Optional Feature:
- Macro CONF_RX_CHECKSUM_EN.
- Defined:
  - Each frame carries a trailing byte equal to the XOR of the address byte and all data bytes.
  - In CHK, the transfer compares the trailing byte with the accumulated checksum.
  - Match → PUSH. Mismatch → IDLE, frame_error pulses one cycle, register_rdy is not asserted.
- Undefined: CHK state and comparator are absent; DATA goes straight to PUSH; frame_error pulses only on timeout.

Decomposition:
- Shared defines file: state encodings, RX_WIDTH, the byte count DATA_WIDTH/8, and the default TIMEOUT_CYCLES.
- __ADDR_WIDTH and __DATA_WIDTH come from the existing configuration register defines.
- One natural sub-module, conf_rx_timeout: a loadable down-counter with clear/enable inputs and an expire output, reusable by other UART-facing blocks.

Test Plan:
- DATA_WIDTH=16, macro off. Send 0x03, 0x34, 0x12 back-to-back → register_rdy=1 one cycle after the third transfer, with addr=0x03, data=0x1234. Hold register_ack=0 for 5 cycles → rx_ack=0 throughout and outputs stable; ack → rdy=0 next cycle.
- TIMEOUT_CYCLES=16. Send 0x05, then idle 20 cycles → frame_error pulses exactly once (16 cycles after the byte), no register_rdy. Then send 0x07, 0xAA, 0x55 → addr=0x07, data=0x55AA.
- Byte arriving exactly at cycle TIMEOUT_CYCLES-1 after the previous byte → accepted, no frame_error, frame completes normally.
- Macro on, DATA_WIDTH=8. Send 0x02, 0x0F, 0x0D → write addr=0x02, data=0x0F. Send 0x02, 0x0F, 0x00 → frame_error pulse, no register_rdy.
- Assert rst=0 for 1 cycle while in PUSH → register_rdy=0 next cycle and all outputs at reset values. The next full frame is parsed correctly from its first byte.
- 50 random frames with rx_rdy jitter and random register_ack delay → scoreboard receives every addr/data pair in order, none lost or duplicated.
